eth_rx_frame_buf: RTL and testbench

Parametrised multi-frame receive buffer between the MAC receive datapath and the system-bus/DMA side of the Ethernet subsystem.
It replaces the single fixed 512x32 receive RAM with a ring of configurable depth and a frame-length FIFO, so several frames can be queued.
Errored, oversized and overflowing frames are discarded atomically, and drop and error counts are kept.
The host reads one frame at a time and releases it explicitly.

---
 rtl/eth_buf_pkg.sv | 24 ++
 rtl/eth_sdp_ram.sv | 23 ++
 rtl/eth_rx_frame_buf.sv | 226 ++++++++++++++++++++++
 tb/tb_eth_rx_frame_buf.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_buf_pkg.sv
// Shared types and width helpers for the Ethernet receive frame buffer.
package eth_buf_pkg;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACCEPT = 2'd1,
    W_DROP   = 2'd2
  } wr_state_e;

  localparam int CNT_W = 16;

  function automatic int bytes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int addr_w_of(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int len_w_of(input int max_frame_bytes);
    return $clog2(max_frame_bytes + 1);
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module eth_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    q_o
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port share the clock; storage is never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) q_o <= mem[raddr_i];
  end

endmodule

// File: rtl/eth_rx_frame_buf.sv
// Multi-frame receive ring: frames are written speculatively and become visible
// to the reader only once committed; bad frames are rewound atomically.
module eth_rx_frame_buf
  import eth_buf_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 512,
  parameter int NUM_FRAMES      = 8,
  parameter int MAX_FRAME_BYTES = 1536
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                wr_valid_i,
  input  logic [DATA_WIDTH-1:0]               wr_data_i,
  input  logic                                wr_last_i,
  input  logic [$clog2(DATA_WIDTH/8):0]       wr_bytes_i,
  input  logic                                wr_err_i,
  output logic                                frame_avail_o,
  output logic [len_w_of(MAX_FRAME_BYTES)-1:0] frame_len_o,
  input  logic                                rd_en_i,
  output logic [DATA_WIDTH-1:0]               rd_data_o,
  output logic                                rd_valid_o,
  input  logic                                frame_done_i,
  output logic [CNT_W-1:0]                    drop_cnt_o,
  output logic [CNT_W-1:0]                    err_cnt_o,
  output logic [addr_w_of(DEPTH):0]           fill_o
);

  localparam int BYTES  = bytes_of(DATA_WIDTH);
  localparam int ADDR_W = addr_w_of(DEPTH);
  localparam int LEN_W  = len_w_of(MAX_FRAME_BYTES);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int FIDX_W = $clog2(NUM_FRAMES);
  localparam int SUM_W  = LEN_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  wr_state_e          state_q, state_d;
  logic [PTR_W-1:0]   wptr_commit, wptr_tmp, rd_base, rd_ptr, rd_off;
  logic [LEN_W-1:0]   bcnt, wcnt;
  logic [SUM_W-1:0]   inc_bytes, new_bytes;
  logic               space_full, oversize, fifo_full, word_bad;
  logic               we, commit, rewind, drop_inc, err_inc;
  logic [LEN_W-1:0]   flen_mem   [NUM_FRAMES];
  logic [LEN_W-1:0]   fwords_mem [NUM_FRAMES];
  logic [FIDX_W:0]    fwr_q, frd_q, fcnt_q, fcnt_d;
  logic               avail_q, pop;
  logic [LEN_W-1:0]   head_len, head_words;
  logic               rd_req_p0, vld_p1;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [CNT_W-1:0]   drop_cnt, err_cnt;

  assign inc_bytes  = wr_last_i ? SUM_W'(wr_bytes_i) : SUM_W'(BYTES);
  assign new_bytes  = {1'b0, bcnt} + inc_bytes;
  assign oversize   = new_bytes > SUM_W'(MAX_FRAME_BYTES);
  assign space_full = (wptr_tmp - rd_base) == PTR_W'(DEPTH);
  assign fifo_full  = fcnt_q == (FIDX_W+1)'(NUM_FRAMES);
  assign word_bad   = space_full || oversize || ((state_q == W_IDLE) && fifo_full);

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= W_IDLE;
    else          state_q <= state_d;
  end

  // Write FSM next state: a last word always returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE, W_ACCEPT: begin
        if (wr_valid_i) begin
          if (wr_last_i)     state_d = W_IDLE;
          else if (word_bad) state_d = W_DROP;
          else               state_d = W_ACCEPT;
        end
      end
      W_DROP: if (wr_valid_i && wr_last_i) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
  end

  // Write FSM outputs; a drop decided on the last word is counted as a drop, not an error.
  always_comb begin
    we       = 1'b0;
    commit   = 1'b0;
    rewind   = 1'b0;
    drop_inc = 1'b0;
    err_inc  = 1'b0;
    case (state_q)
      W_IDLE, W_ACCEPT: begin
        if (wr_valid_i) begin
          if (word_bad) begin
            rewind   = 1'b1;
            drop_inc = wr_last_i;
          end else begin
            we = 1'b1;
            if (wr_last_i) begin
              if (wr_err_i) begin
                rewind  = 1'b1;
                err_inc = 1'b1;
              end else begin
                commit = 1'b1;
              end
            end
          end
        end
      end
      W_DROP: begin
        rewind   = 1'b1;
        drop_inc = wr_valid_i && wr_last_i;
      end
      default: ;
    endcase
  end

  // Speculative write pointer and running frame size; commit publishes, rewind discards.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wptr_commit <= '0;
      wptr_tmp    <= '0;
      bcnt        <= '0;
      wcnt        <= '0;
    end else if (commit) begin
      wptr_commit <= wptr_tmp + 1'b1;
      wptr_tmp    <= wptr_tmp + 1'b1;
      bcnt        <= '0;
      wcnt        <= '0;
    end else if (rewind) begin
      wptr_tmp <= wptr_commit;
      bcnt     <= '0;
      wcnt     <= '0;
    end else if (we) begin
      wptr_tmp <= wptr_tmp + 1'b1;
      bcnt     <= new_bytes[LEN_W-1:0];
      wcnt     <= wcnt + 1'b1;
    end
  end

  assign pop = frame_done_i && avail_q;

  always_comb begin
    fcnt_d = fcnt_q;
    if (commit && !pop)      fcnt_d = fcnt_q + 1'b1;
    else if (!commit && pop) fcnt_d = fcnt_q - 1'b1;
  end

  // Length FIFO control; availability is registered from the next count.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fwr_q   <= '0;
      frd_q   <= '0;
      fcnt_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      fwr_q   <= fwr_q + (FIDX_W+1)'(commit);
      frd_q   <= frd_q + (FIDX_W+1)'(pop);
      fcnt_q  <= fcnt_d;
      avail_q <= fcnt_d != '0;
    end
  end

  // Length FIFO storage: byte length and word count of each committed frame.
  always_ff @(posedge clk_i) begin
    if (commit) begin
      flen_mem[fwr_q[FIDX_W-1:0]]   <= new_bytes[LEN_W-1:0];
      fwords_mem[fwr_q[FIDX_W-1:0]] <= wcnt + 1'b1;
    end
  end

  assign head_len   = flen_mem[frd_q[FIDX_W-1:0]];
  assign head_words = fwords_mem[frd_q[FIDX_W-1:0]];
  assign rd_off     = rd_ptr - rd_base;
  assign rd_req_p0  = rd_en_i && avail_q && (32'(rd_off) < 32'(head_words));

  // Read stage p0 -> p1: read pointer, frame release and output valid.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_base <= '0;
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_req_p0;
      if (pop) begin
        rd_base <= rd_base + PTR_W'(head_words);
        rd_ptr  <= rd_base + PTR_W'(head_words);
      end else if (rd_req_p0) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Saturating drop and error counters.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
      if (err_inc)  err_cnt  <= sat_inc(err_cnt);
    end
  end

  eth_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (wptr_tmp[ADDR_W-1:0]),
    .wdata_i (wr_data_i),
    .re_i    (rd_req_p0),
    .raddr_i (rd_ptr[ADDR_W-1:0]),
    .q_o     (ram_q)
  );

  assign frame_avail_o = avail_q;
  assign frame_len_o   = avail_q ? head_len : '0;
  assign rd_valid_o    = vld_p1;
  assign rd_data_o     = vld_p1 ? ram_q : '0;
  assign drop_cnt_o    = drop_cnt;
  assign err_cnt_o     = err_cnt;
  assign fill_o        = wptr_commit - rd_base;

endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Randomised scoreboard bench for eth_rx_frame_buf with a frame-level reference model.
module tb_eth_rx_frame_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int NF    = 4;
  localparam int MAXB  = 256;
  localparam int LEN_W = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic [DW-1:0]    wr_data = '0;
  logic             wr_last = 1'b0;
  logic [2:0]       wr_bytes = '0;
  logic             wr_err = 1'b0;
  logic             frame_avail;
  logic [LEN_W-1:0] frame_len;
  logic             rd_en = 1'b0;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic             frame_done = 1'b0;
  logic [15:0]      drop_cnt, err_cnt;
  logic [6:0]       fill;

  eth_rx_frame_buf #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .NUM_FRAMES      (NF),
    .MAX_FRAME_BYTES (MAXB)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_n),
    .wr_valid_i    (wr_valid),
    .wr_data_i     (wr_data),
    .wr_last_i     (wr_last),
    .wr_bytes_i    (wr_bytes),
    .wr_err_i      (wr_err),
    .frame_avail_o (frame_avail),
    .frame_len_o   (frame_len),
    .rd_en_i       (rd_en),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .frame_done_i  (frame_done),
    .drop_cnt_o    (drop_cnt),
    .err_cnt_o     (err_cnt),
    .fill_o        (fill)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed words in arrival order, per-frame length and word count.
  logic [31:0] m_words[$];
  int          m_len[$];
  int          m_nw[$];
  int          m_drop = 0;
  int          m_err  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_pop();
    if (m_len.size() > 0) begin
      repeat (m_nw[0]) void'(m_words.pop_front());
      void'(m_nw.pop_front());
      void'(m_len.pop_front());
    end
  endtask

  task automatic check_head();
    check("frame_avail", frame_avail, m_len.size() > 0);
    check("frame_len", frame_len, (m_len.size() > 0) ? m_len[0] : 0);
    check("fill", fill, m_words.size());
    check("drop_cnt", drop_cnt, m_drop);
    check("err_cnt", err_cnt, m_err);
  endtask

  // Monitor: every word the DUT presents must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", rd_valid, 0);
      end else begin
        check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_frame(input int nbytes, input bit err, input bit done_last);
    int          nw;
    bit          drop;
    logic [31:0] w[$];
    nw   = (nbytes + 3) / 4;
    drop = (m_len.size() == NF) || (nbytes > MAXB) || (m_words.size() + nw > DEPTH);
    for (int i = 0; i < nw; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        tick();
      end
      wr_valid   = 1'b1;
      wr_data    = $urandom;
      wr_last    = (i == nw - 1);
      wr_bytes   = wr_last ? 3'(nbytes - 4 * (nw - 1)) : 3'($urandom_range(0, 7));
      wr_err     = wr_last ? err : 1'($urandom_range(0, 1));
      frame_done = wr_last && done_last;
      w.push_back(wr_data);
      tick();
    end
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    wr_err     = 1'b0;
    frame_done = 1'b0;
    if (done_last) model_pop();
    if (drop) m_drop++;
    else if (err) m_err++;
    else begin
      foreach (w[k]) m_words.push_back(w[k]);
      m_len.push_back(nbytes);
      m_nw.push_back(nw);
    end
    check_head();
  endtask

  task automatic read_frame(input int nreads);
    int nw;
    nw = (m_len.size() > 0) ? m_nw[0] : 0;
    for (int r = 0; r < nreads; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        rd_en = 1'b0;
        tick();
      end
      rd_en = 1'b1;
      if (r < nw) exp_q.push_back(m_words[r]);
      tick();
    end
    rd_en = 1'b0;
    tick();
    tick();
    check("rd_words_outstanding", exp_q.size(), 0);
    exp_q.delete();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    model_pop();
    check_head();
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    wr_err     = 1'b0;
    rd_en      = 1'b0;
    frame_done = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    m_words.delete();
    m_len.delete();
    m_nw.delete();
    exp_q.delete();
    m_drop = 0;
    m_err  = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avail"}, frame_avail, 0);
    check({tag, "_len"}, frame_len, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_err"}, err_cnt, 0);
    check({tag, "_fill"}, fill, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_all_zero("reset");

    // Single 64-byte frame, full read.
    send_frame(64, 0, 0);
    read_frame(16);

    // Back-to-back frames with odd tails; partial read then release, and over-read.
    send_frame(61, 0, 0);
    send_frame(100, 0, 0);
    send_frame(250, 0, 0);
    read_frame(5);
    read_frame(25);
    read_frame(66);

    // Errored frame is rewound; the next good frame reuses the space.
    send_frame(40, 1, 0);
    send_frame(40, 0, 0);
    read_frame(10);

    // Ring overflow, then wrap after release.
    send_frame(200, 0, 0);
    send_frame(100, 0, 0);
    read_frame(0);
    send_frame(100, 0, 0);
    read_frame(25);

    // Length FIFO full, then oversize.
    for (int i = 0; i < NF + 1; i++) send_frame(8, 0, 0);
    send_frame(MAXB + 4, 0, 0);
    for (int i = 0; i < NF; i++) read_frame(2);

    // Reads while empty are ignored.
    read_frame(3);

    // Commit and release in the same cycle.
    send_frame(20, 0, 0);
    send_frame(12, 0, 1);
    send_frame(4, 0, 1);
    read_frame(1);

    // Randomised traffic.
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        int len;
        len = ($urandom_range(0, 7) == 0) ? $urandom_range(240, 300) : $urandom_range(1, 120);
        send_frame(len, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
      end else begin
        read_frame($urandom_range(0, 34));
      end
    end

    // Reset in the middle of a frame.
    send_frame(16, 0, 0);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = $urandom;
      wr_last  = 1'b0;
      tick();
    end
    do_reset();
    check_all_zero("midreset");
    send_frame(24, 0, 0);
    read_frame(6);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
